aes_result_collector: RTL and testbench

- Sits at the output end of the modified AES-256 core; complements the stimulus side that drives key, data_in and sbox_seed.
- Aligns each accepted plaintext block with the core's data_out_enc and data_out_dec after a fixed core latency.
- Checks round-trip integrity (data_out_dec == original data_in) and buffers results in a FIFO.
- Streams results out over a valid/ready handshake and keeps block and error counters.

---
 rtl/aes_result_collector.sv | 176 +++++++++++++++++
 tb/tb_aes_result_collector.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_collector.sv
// Output-side collector for the modified AES-256 core: aligns core outputs with delayed
// plaintext, checks round-trip, buffers results. Optional macro AES_RES_PLAINTEXT_EN adds res_plain.
module aes_result_collector #(
  parameter int LAT   = 14,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [127:0]       data_in,
  input  logic [127:0]       data_out_enc,
  input  logic [127:0]       data_out_dec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [127:0]       res_enc,
  output logic [127:0]       res_dec,
  output logic               res_match,
`ifdef AES_RES_PLAINTEXT_EN
  output logic [127:0]       res_plain,
`endif
  output logic [CNT_W-1:0]   blk_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);
`ifdef AES_RES_PLAINTEXT_EN
  localparam int EW = 385;
`else
  localparam int EW = 257;
`endif
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LAT-1:0] vld_q, vld_d;
  logic [127:0]   dly_q [LAT];
  logic [127:0]   dly_d [LAT];

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [EW-1:0]    head_q, head_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] blk_q, blk_d, err_q, err_d, drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic          cap_match_s;
  logic [EW-1:0] cap_entry_s;
  logic          full_s, push_req_s, pop_s, push_ok_s, drop_s;

  // Delay line shifts unconditionally; the core never stalls.
  always_comb begin
    vld_d    = {LAT{1'b0}};
    vld_d[0] = in_valid;
    dly_d[0] = data_in;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dly_d[i] = dly_q[i-1];
    end
  end

  // Result entry formed from the core outputs and the plaintext aligned with them.
  always_comb begin
    cap_match_s = (data_out_dec == dly_q[LAT-1]);
`ifdef AES_RES_PLAINTEXT_EN
    cap_entry_s = {dly_q[LAT-1], data_out_enc, data_out_dec, cap_match_s};
`else
    cap_entry_s = {data_out_enc, data_out_dec, cap_match_s};
`endif
  end

  // FIFO control, head register and counters.
  always_comb begin
    full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_req_s = vld_q[LAT-1];
    pop_s      = res_valid_q && res_ready;
    push_ok_s  = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;

    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    mem_d = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = cap_entry_s;
    end else begin
      mem_d = mem_q;
    end

    // Head is loaded one cycle ahead so outputs come straight from flops; the entry
    // being written this cycle becomes head only when it is the sole survivor.
    res_valid_d = (wr_ptr_d != rd_ptr_d);
    head_d      = head_q;
    if (res_valid_d) begin
      if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
        head_d = cap_entry_s;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end else begin
      head_d = head_q;
    end

    blk_d = blk_q;
    if (push_ok_s && (blk_q != CNT_MAX)) begin
      blk_d = blk_q + CNT_ONE;
    end else begin
      blk_d = blk_q;
    end

    err_d = err_q;
    if (push_ok_s && !cap_match_s && (err_q != CNT_MAX)) begin
      err_d = err_q + CNT_ONE;
    end else begin
      err_d = err_q;
    end

    drop_d = drop_q;
    if (drop_s && (drop_q != CNT_MAX)) begin
      drop_d = drop_q + CNT_ONE;
    end else begin
      drop_d = drop_q;
    end

    ovf_d = ovf_q | drop_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q       <= {LAT{1'b0}};
      wr_ptr_q    <= {(AW+1){1'b0}};
      rd_ptr_q    <= {(AW+1){1'b0}};
      head_q      <= {EW{1'b0}};
      res_valid_q <= 1'b0;
      blk_q       <= {CNT_W{1'b0}};
      err_q       <= {CNT_W{1'b0}};
      drop_q      <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        dly_q[i] <= 128'h0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else begin
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_q      <= head_d;
      res_valid_q <= res_valid_d;
      blk_q       <= blk_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      dly_q       <= dly_d;
      mem_q       <= mem_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_enc   = head_q[256:129];
  assign res_dec   = head_q[128:1];
  assign res_match = head_q[0];
`ifdef AES_RES_PLAINTEXT_EN
  assign res_plain = head_q[384:257];
`endif
  assign blk_cnt   = blk_q;
  assign err_cnt   = err_q;
  assign drop_cnt  = drop_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_aes_result_collector.sv
// Self-checking bench for aes_result_collector: bench acts as the AES core and
// predicts results with a queue-based model; a CNT_W=4 instance checks saturation.
module tb_aes_result_collector;
  localparam int LAT   = 14;
  localparam int DEPTH = 8;
  localparam int NSLOT = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [127:0] data_in = 128'h0;
  logic [127:0] data_out_enc = 128'h0;
  logic [127:0] data_out_dec = 128'h0;

  logic         res_valid, res_match, overflow;
  logic [127:0] res_enc, res_dec;
  logic [15:0]  blk_cnt, err_cnt, drop_cnt;
  logic         s_res_valid, s_res_match, s_overflow;
  logic [127:0] s_res_enc, s_res_dec;
  logic [3:0]   s_blk, s_err, s_drop;
`ifdef AES_RES_PLAINTEXT_EN
  logic [127:0] res_plain, s_res_plain;
`endif

  aes_result_collector #(.LAT(LAT), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .data_out_enc(data_out_enc), .data_out_dec(data_out_dec),
    .res_valid(res_valid), .res_ready(res_ready), .res_enc(res_enc),
    .res_dec(res_dec), .res_match(res_match),
`ifdef AES_RES_PLAINTEXT_EN
    .res_plain(res_plain),
`endif
    .blk_cnt(blk_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  aes_result_collector #(.LAT(LAT), .DEPTH(DEPTH), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .data_out_enc(data_out_enc), .data_out_dec(data_out_dec),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_enc(s_res_enc),
    .res_dec(s_res_dec), .res_match(s_res_match),
`ifdef AES_RES_PLAINTEXT_EN
    .res_plain(s_res_plain),
`endif
    .blk_cnt(s_blk), .err_cnt(s_err), .drop_cnt(s_drop), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] enc;
    logic [127:0] dec;
    logic [127:0] plain;
    logic         match;
  } ent_t;

  ent_t         q[$];
  ent_t         last;
  bit           s_vld [NSLOT];
  logic [127:0] s_plain [NSLOT];
  logic [127:0] s_enc [NSLOT];
  logic [127:0] s_dec [NSLOT];
  int           m_blk, m_err, m_drop;
  bit           m_ovf;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("res_valid", 128'(res_valid), 128'(q.size() != 0));
    chk("res_enc", res_enc, last.enc);
    chk("res_dec", res_dec, last.dec);
    chk("res_match", 128'(res_match), 128'(last.match));
    chk("blk_cnt", 128'(blk_cnt), 128'(sat(m_blk, 65535)));
    chk("err_cnt", 128'(err_cnt), 128'(sat(m_err, 65535)));
    chk("drop_cnt", 128'(drop_cnt), 128'(sat(m_drop, 65535)));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("sat_valid", 128'(s_res_valid), 128'(q.size() != 0));
    chk("sat_enc", s_res_enc, last.enc);
    chk("sat_blk", 128'(s_blk), 128'(sat(m_blk, 15)));
    chk("sat_err", 128'(s_err), 128'(sat(m_err, 15)));
    chk("sat_drop", 128'(s_drop), 128'(sat(m_drop, 15)));
`ifdef AES_RES_PLAINTEXT_EN
    chk("res_plain", res_plain, last.plain);
`endif
  endtask

  // One clock edge: update the reference model with what was sampled, then check.
  task automatic tick();
    int slot;
    bit pop;
    @(posedge clk);
    slot = cyc % NSLOT;
    pop  = (q.size() != 0) && res_ready;
    if (s_vld[slot]) begin
      ent_t e;
      e.enc   = s_enc[slot];
      e.dec   = s_dec[slot];
      e.plain = s_plain[slot];
      e.match = (s_dec[slot] == s_plain[slot]);
      if ((q.size() < DEPTH) || pop) begin
        q.push_back(e);
        m_blk++;
        if (!e.match) m_err++;
      end else begin
        m_drop++;
        m_ovf = 1'b1;
      end
      s_vld[slot] = 1'b0;
    end
    if (pop) void'(q.pop_front());
    if (q.size() != 0) last = q[0];
    cyc++;
    #1;
    check_all();
  endtask

  // Drive one cycle of stimulus; a sent block's core outputs appear LAT cycles later.
  task automatic drive(bit v, logic [127:0] p, logic [127:0] d, bit rdy);
    int slot;
    in_valid  = v;
    data_in   = v ? p : rnd128();
    res_ready = rdy;
    if (v) begin
      slot = (cyc + LAT) % NSLOT;
      s_vld[slot]   = 1'b1;
      s_plain[slot] = p;
      s_enc[slot]   = rnd128();
      s_dec[slot]   = d;
    end
    slot = cyc % NSLOT;
    if (s_vld[slot]) begin
      data_out_enc = s_enc[slot];
      data_out_dec = s_dec[slot];
    end else begin
      data_out_enc = rnd128();
      data_out_dec = rnd128();
    end
    tick();
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 128'h0, 128'h0, rdy);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    q.delete();
    last.enc = 128'h0; last.dec = 128'h0; last.plain = 128'h0; last.match = 1'b0;
    m_blk = 0; m_err = 0; m_drop = 0; m_ovf = 1'b0;
    for (int i = 0; i < NSLOT; i++) s_vld[i] = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    cyc++;
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    logic [127:0] p;
    int           d0;
    int           n;
    #2;
    do_reset();

    // Single matching block: res_valid appears exactly LAT+1 cycles after in_valid.
    p = 128'h00112233445566778899aabbccddeeff;
    drive(1'b1, p, p, 1'b0);
    idle(LAT - 1, 1'b0);
    chk("lat_early", 128'(res_valid), 128'h0);
    idle(1, 1'b0);
    chk("lat_valid", 128'(res_valid), 128'h1);
    chk("t1_match", 128'(res_match), 128'h1);
    chk("t1_dec", res_dec, 128'h00112233445566778899aabbccddeeff);
    chk("t1_blk", 128'(blk_cnt), 128'h1);
    chk("t1_err", 128'(err_cnt), 128'h0);
    idle(1, 1'b1);
    chk("t1_popped", 128'(res_valid), 128'h0);

    // Mismatching block.
    do_reset();
    drive(1'b1, p, 128'h0, 1'b0);
    idle(LAT, 1'b0);
    chk("t2_match", 128'(res_match), 128'h0);
    chk("t2_err", 128'(err_cnt), 128'h1);
    chk("t2_blk", 128'(blk_cnt), 128'h1);
    idle(2, 1'b1);

    // Back-pressure: 10 blocks into 8 slots.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      p = rnd128();
      drive(1'b1, p, p, 1'b0);
    end
    idle(LAT + 1, 1'b0);
    chk("bp_blk", 128'(blk_cnt), 128'h8);
    chk("bp_drop", 128'(drop_cnt), 128'h2);
    chk("bp_ovf", 128'(overflow), 128'h1);
    idle(7, 1'b1);
    chk("bp_7th", 128'(res_valid), 128'h1);
    idle(1, 1'b1);
    chk("bp_drained", 128'(res_valid), 128'h0);
    idle(2, 1'b1);

    // Push and pop together while full: no drop, occupancy stays DEPTH.
    for (int i = 0; i < 9; i++) begin
      p = rnd128();
      drive(1'b1, p, p, 1'b0);
    end
    idle(LAT - 1, 1'b0);
    chk("pp_full", 128'(res_valid), 128'h1);
    d0 = m_drop;
    idle(1, 1'b1);
    chk("pp_nodrop", 128'(drop_cnt), 128'(d0));
    n = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        n++;
        idle(1, 1'b1);
      end
    end
    chk("pp_occupancy", 128'(n), 128'h8);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      p = rnd128();
      drive(1'($urandom_range(0, 1)), p, ($urandom_range(0, 3) != 0) ? p : rnd128(),
            1'($urandom_range(0, 1)));
    end
    idle(DEPTH + LAT + 2, 1'b1);

    // Reset with 3 blocks in the delay line and 2 in the FIFO.
    for (int i = 0; i < 5; i++) begin
      p = rnd128();
      drive(1'b1, p, p, 1'b0);
    end
    idle(LAT - 3, 1'b0);
    chk("mr_pre_valid", 128'(res_valid), 128'h1);
    do_reset();
    chk("mr_valid", 128'(res_valid), 128'h0);
    chk("mr_blk", 128'(blk_cnt), 128'h0);
    idle(2 * LAT, 1'b1);
    chk("mr_quiet", 128'(res_valid), 128'h0);
    chk("mr_blk_after", 128'(blk_cnt), 128'h0);

    // Saturation on the CNT_W=4 instance.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      p = rnd128();
      drive(1'b1, p, ~p, 1'b1);
    end
    idle(LAT + 3, 1'b1);
    chk("sat_blk15", 128'(s_blk), 128'hf);
    chk("sat_err15", 128'(s_err), 128'hf);
    chk("wide_blk20", 128'(blk_cnt), 128'd20);
    chk("wide_err20", 128'(err_cnt), 128'd20);
    for (int i = 0; i < 5; i++) begin
      p = rnd128();
      drive(1'b1, p, ~p, 1'b1);
    end
    idle(LAT + 3, 1'b1);
    chk("sat_hold", 128'(s_blk), 128'hf);
    chk("wide_blk25", 128'(blk_cnt), 128'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
